// File: rtl/cpuex_mem_pkg.sv
// Shared memory-subsystem constants and owner encoding, used by the RAM,
// the core and the port-0 arbiter.
package cpuex_mem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      ST_OPEN   = 2'd0,
      ST_LOCK_A = 2'd1,
      ST_LOCK_B = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for RAM port 0 between the load/store unit (A) and the
// UART loader (B), with a bounded burst lock and 1-cycle read response.
module mem_port_arbiter
   import cpuex_mem_pkg::*;
#(
   parameter int ADDR_W    = cpuex_mem_pkg::ADDR_W,
   parameter int DATA_W    = cpuex_mem_pkg::DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rstn,

   input  logic              a_req,
   input  logic              a_lock,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,

   input  logic              b_req,
   input  logic              b_lock,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,

   output logic              ram_port_en,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam logic [7:0] MAX_B8 = 8'(MAX_BURST);

   arb_state_e state;
   owner_e     last_grant;
   logic [7:0] burst_cnt;

   logic acc_a, acc_b, acc_lock, owner_held;
   logic [7:0] next_cnt;

   // A lock whose owner dropped req behaves as OPEN in that same cycle.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (rstn) begin
         if (state == ST_LOCK_A && a_req)
            a_gnt = 1'b1;
         else if (state == ST_LOCK_B && b_req)
            b_gnt = 1'b1;
         else if (a_req && b_req) begin
            if (last_grant == OWN_A) b_gnt = 1'b1;
            else                     a_gnt = 1'b1;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   assign acc_a      = a_req & a_gnt;
   assign acc_b      = b_req & b_gnt;
   assign acc_lock   = acc_a ? a_lock : b_lock;
   assign owner_held = (state == ST_LOCK_A && a_req) || (state == ST_LOCK_B && b_req);
   assign next_cnt   = burst_cnt + 8'd1;

   always_comb begin
      ram_port_en = 1'b0;
      ram_wr_en   = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      if (acc_a) begin
         ram_port_en = 1'b1;
         ram_wr_en   = a_we;
         ram_addr    = a_addr;
         ram_wdata   = a_wdata;
      end else if (acc_b) begin
         ram_port_en = 1'b1;
         ram_wr_en   = b_we;
         ram_addr    = b_addr;
         ram_wdata   = b_wdata;
      end
   end

   // Read data comes straight from the RAM's output register; rvalid qualifies it.
   assign a_rdata = ram_data_out;
   assign b_rdata = ram_data_out;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= ST_OPEN;
         last_grant <= OWN_B;
         burst_cnt  <= 8'd0;
         a_rvalid   <= 1'b0;
         b_rvalid   <= 1'b0;
      end else begin
         a_rvalid <= acc_a & ~a_we;
         b_rvalid <= acc_b & ~b_we;

         if (acc_a)      last_grant <= OWN_A;
         else if (acc_b) last_grant <= OWN_B;

         if (owner_held) begin
            // The owner's beat is always accepted here; the limit beat still completes.
            if (!acc_lock || next_cnt >= MAX_B8) begin
               state     <= ST_OPEN;
               burst_cnt <= 8'd0;
            end else begin
               burst_cnt <= next_cnt;
            end
         end else if ((acc_a || acc_b) && acc_lock && MAX_B8 > 8'd1) begin
            state     <= acc_a ? ST_LOCK_A : ST_LOCK_B;
            burst_cnt <= 8'd1;
         end else begin
            state     <= ST_OPEN;
            burst_cnt <= 8'd0;
         end
      end
   end

endmodule
